pmod_jstk_spi: RTL and testbench

- SPI master that polls a Digilent PmodJSTK joystick module.
- On each request it exchanges a 5-byte frame: it sends the command byte DIN followed by four 0x00 bytes, and captures the 5 bytes returned on MISO.
- The captured frame is presented as a 40-bit word, DOUT, to game logic, which extracts X/Y position and button state from it.
- SPI mode 0, MSB first, running on the 100 MHz system clock.

---
 rtl/pmod_jstk_spi.sv | 177 +++++++++++++++++
 tb/tb_pmod_jstk_spi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_jstk_spi.sv
// SPI mode-0 master that polls a PmodJSTK joystick with a 5-byte frame.
// Sends DIN followed by four 0x00 bytes and captures the returned bytes into DOUT.
module pmod_jstk_spi #(
  parameter int unsigned SCLK_HALF = 750,
  parameter int unsigned SS_LEAD   = 1500,
  parameter int unsigned BYTE_GAP  = 1000,
  parameter int unsigned SS_TRAIL  = 750
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sndRec,
  input  logic [7:0]  DIN,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SCLK,
  output logic        SS,
  output logic [39:0] DOUT
);

  localparam int unsigned NUM_BYTES = 5;
  localparam int unsigned DW        = 8 * NUM_BYTES;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(SS_LEAD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(SS_TRAIL - 1);
  localparam logic [2:0]       LAST_BYTE  = 3'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [7:0]        tx_q, tx_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [1:0]        sync_q;
  logic              sr_prev_q;
  logic              start_c;

  // Rising edge of the synchronized request; only honoured while idle
  assign start_c = sync_q[1] & ~sr_prev_q;

  // Request synchronizer and edge-detector history
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= 2'b00;
      sr_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], sndRec};
      sr_prev_q <= sync_q[1];
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= '0;
      dout_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // Frame sequencing: next state, SPI pins and shift registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = LEAD;
          ss_d    = 1'b0;
          tx_d    = DIN;
          mosi_d  = DIN[7];
          rx_d    = '0;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
        end
      end
      LEAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LEAD_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[DW-2:0], MISO};
        end
        if (cnt_q == BIT_LAST) begin
          // Zeros shift in behind DIN, so bytes 1..4 go out as 0x00
          sclk_d = 1'b0;
          cnt_d  = '0;
          tx_d   = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d  = byte_q + 3'd1;
            state_d = (byte_q == LAST_BYTE) ? TRAIL : GAP;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      TRAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TRAIL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          dout_d  = rx_q;
        end
      end
      default: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  assign MOSI = mosi_q;
  assign SCLK = sclk_q;
  assign SS   = ss_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_pmod_jstk_spi.sv
// Directed bench for pmod_jstk_spi with a mode-0 joystick slave model.
module tb_pmod_jstk_spi;

  localparam int FRAME_LEN = 356;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sndRec = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        MISO = 1'b0;
  logic        MOSI;
  logic        SCLK;
  logic        SS;
  logic [39:0] DOUT;

  int checks = 0;
  int errors = 0;

  // Slave / monitor state
  logic        mon_en = 1'b0;
  logic [39:0] slave_data = 40'h0;
  logic [39:0] sl = 40'h0;
  logic        ss_p = 1'b1;
  logic        sclk_p = 1'b0;
  logic [39:0] dout_p = 40'h0;
  int          low_len = 0;
  int          sclk_rises = 0;
  logic [39:0] mosi_bits = 40'h0;
  int          frames_done = 0;
  int          last_len = 0;
  int          last_rises = 0;
  logic [39:0] last_mosi = 40'h0;
  int          idle_viol = 0;
  int          dout_viol = 0;
  int          len_bad = 0;
  logic        fr_run = 1'b0;

  pmod_jstk_spi #(
    .SCLK_HALF(4),
    .SS_LEAD  (8),
    .BYTE_GAP (6),
    .SS_TRAIL (4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .sndRec(sndRec),
    .DIN   (DIN),
    .MISO  (MISO),
    .MOSI  (MOSI),
    .SCLK  (SCLK),
    .SS    (SS),
    .DOUT  (DOUT)
  );

  always #5 CLK = ~CLK;

  // Joystick slave (shifts MISO on SCLK falling) and bus monitor
  always @(negedge CLK) begin
    if (mon_en) begin
      if (ss_p && !SS) begin
        sl         = slave_data;
        low_len    = 0;
        sclk_rises = 0;
        mosi_bits  = 40'h0;
      end else if (sclk_p && !SCLK) begin
        sl = {sl[38:0], 1'b0};
      end
      if (!SS) low_len++;
      if (!sclk_p && SCLK) begin
        sclk_rises++;
        mosi_bits = {mosi_bits[38:0], MOSI};
      end
      if (SS && (SCLK || MOSI)) idle_viol++;
      if (SS && ss_p && (SCLK != sclk_p)) idle_viol++;
      if (!ss_p && SS) begin
        frames_done++;
        last_len   = low_len;
        last_rises = sclk_rises;
        last_mosi  = mosi_bits;
        if (low_len != FRAME_LEN) len_bad++;
      end else if (DOUT !== dout_p) begin
        dout_viol++;
      end
      MISO = sl[39];
    end
    ss_p   = SS;
    sclk_p = SCLK;
    dout_p = DOUT;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge CLK);
    sndRec = 1'b1;
    repeat (3) @(negedge CLK);
    sndRec = 1'b0;
  endtask

  task automatic wait_frame(input int n0, input string tag);
    int k;
    k = 0;
    while (frames_done == n0 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 64'(frames_done != n0), 64'd1);
  endtask

  task automatic wait_ss_low(input string tag);
    int k;
    k = 0;
    while (SS !== 1'b0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 64'(SS), 64'd0);
  endtask

  initial begin
    int n0;
    int iv0;
    int dv0;
    int lb0;
    int k;

    // 1. Reset with sndRec toggling
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_ss", 64'(SS), 64'd1);
      check("rst_sclk", 64'(SCLK), 64'd0);
      check("rst_mosi", 64'(MOSI), 64'd0);
      check("rst_dout", 64'(DOUT), 64'd0);
      sndRec = ~sndRec;
    end
    sndRec = 1'b0;
    RST    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge CLK);
    check("post_rst_idle_ss", 64'(SS), 64'd1);
    check("post_rst_frames", 64'(frames_done), 64'd0);

    // 2. Single frame
    DIN        = 8'h82;
    slave_data = 40'h5A03C40105;
    n0 = frames_done;
    pulse();
    wait_frame(n0, "f1_timeout");
    check("f1_len", 64'(last_len), 64'(FRAME_LEN));
    check("f1_rises", 64'(last_rises), 64'd40);
    check("f1_mosi", 64'(last_mosi), 64'h8200000000);
    check("f1_dout", 64'(DOUT), 64'h5A03C40105);
    check("f1_buttons", 64'(DOUT[2:0]), 64'd5);
    check("f1_ss_high", 64'(SS), 64'd1);

    // 3. DIN change during byte 0 is not seen until the next frame
    n0 = frames_done;
    @(negedge CLK);
    sndRec = 1'b1;
    wait_ss_low("f2_ss_low");
    repeat (20) @(negedge CLK);
    DIN    = 8'h81;
    sndRec = 1'b0;
    wait_frame(n0, "f2_timeout");
    check("f2_mosi_latched", 64'(last_mosi), 64'h8200000000);
    n0 = frames_done;
    pulse();
    wait_frame(n0, "f3_timeout");
    check("f3_mosi_new", 64'(last_mosi), 64'h8100000000);
    check("f3_dout", 64'(DOUT), 64'h5A03C40105);

    // 4. Free-running sndRec, period 20
    slave_data = 40'h123456789A;
    n0  = frames_done;
    iv0 = idle_viol;
    dv0 = dout_viol;
    lb0 = len_bad;
    @(negedge CLK);
    fr_run = 1'b1;
    fork
      begin
        while (fr_run) begin
          #10;
          sndRec = ~sndRec;
        end
        sndRec = 1'b0;
      end
    join_none
    k = 0;
    while (frames_done < n0 + 3 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    fr_run = 1'b0;
    repeat (5) @(negedge CLK);
    k = 0;
    while (SS !== 1'b1 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    repeat (5) @(negedge CLK);
    check("fr_frames", 64'(frames_done >= n0 + 3), 64'd1);
    check("fr_idle_viol", 64'(idle_viol - iv0), 64'd0);
    check("fr_dout_viol", 64'(dout_viol - dv0), 64'd0);
    check("fr_len_bad", 64'(len_bad - lb0), 64'd0);
    check("fr_dout", 64'(DOUT), 64'h123456789A);

    // 5. Reset in the middle of byte 2
    slave_data = 40'hA1B2C3D4E5;
    @(negedge CLK);
    sndRec = 1'b1;
    wait_ss_low("ab_ss_low");
    repeat (175) @(negedge CLK);
    sndRec = 1'b0;
    check("ab_mid_ss", 64'(SS), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("ab_ss", 64'(SS), 64'd1);
    check("ab_sclk", 64'(SCLK), 64'd0);
    check("ab_mosi", 64'(MOSI), 64'd0);
    check("ab_dout", 64'(DOUT), 64'd0);
    repeat (10) @(negedge CLK);
    check("ab_no_restart", 64'(SS), 64'd1);
    n0 = frames_done;
    pulse();
    wait_frame(n0, "ab_new_timeout");
    check("ab_new_rises", 64'(last_rises), 64'd40);
    check("ab_new_len", 64'(last_len), 64'(FRAME_LEN));
    check("ab_new_dout", 64'(DOUT), 64'hA1B2C3D4E5);

    // 6. All-ones then all-zeros frames
    slave_data = 40'hFFFFFFFFFF;
    n0 = frames_done;
    pulse();
    wait_frame(n0, "ff_timeout");
    check("ff_dout", 64'(DOUT), 64'hFFFFFFFFFF);
    slave_data = 40'h0000000000;
    n0 = frames_done;
    pulse();
    wait_ss_low("zz_ss_low");
    repeat (100) @(negedge CLK);
    check("ff_hold", 64'(DOUT), 64'hFFFFFFFFFF);
    wait_frame(n0, "zz_timeout");
    check("zz_dout", 64'(DOUT), 64'h0000000000);
    repeat (50) @(negedge CLK);
    check("zz_hold", 64'(DOUT), 64'h0000000000);
    check("final_idle_viol", 64'(idle_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
